// File: rtl/retire_ctrl_pkg.sv
// Shared definitions for the retire stage: widths, ROB head packet and
// retire FSM state encoding. Width macros may be overridden on the
// command line; defaults give a 3-wide machine with a 32-entry ROB.
`ifndef N
`define N 3
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef ROB_SZ_BITS
`define ROB_SZ_BITS $clog2(`ROB_SZ)
`endif
`ifndef PHYS_REG_BITS
`define PHYS_REG_BITS 6
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N + 1)
`endif

package retire_ctrl_pkg;

    localparam int N               = `N;
    localparam int ROB_SZ          = `ROB_SZ;
    localparam int ROB_SZ_BITS     = `ROB_SZ_BITS;
    localparam int PHYS_REG_BITS   = `PHYS_REG_BITS;
    localparam int NUM_SCALAR_BITS = `NUM_SCALAR_BITS;
    localparam int SLOT_BITS       = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } RETIRE_STATE;

    typedef struct packed {
        logic                     complete;
        logic                     is_store;
        logic                     is_branch;
        logic                     mispredict;
        logic                     halt;
        logic                     has_dest;
        logic [PHYS_REG_BITS-1:0] told_reg;
    } ROB_PACKET;

endpackage

// File: rtl/retire_ctrl_scan.sv
// In-order scan of the ROB head window. Purely combinational: reports how
// many slots may retire this cycle, the last retired slot, whether that
// slot ends the scan with a mispredict or a halt, and whether a store
// was among the retired slots (at most one store per cycle).
module retire_scan
    import retire_ctrl_pkg::*;
(
    input  ROB_PACKET [N-1:0]           rob_outputs,
    input  logic [NUM_SCALAR_BITS-1:0]  rob_outputs_valid,
    input  logic                        sq_retire_ready,
    output logic [NUM_SCALAR_BITS-1:0]  count,
    output logic [SLOT_BITS-1:0]        stop_slot,
    output logic                        mispredict,
    output logic                        halt,
    output logic                        store
);

    logic stop_s;
    logic unused_branch_s;

    // Branch flag is carried in the packet but only mispredict matters here.
    always_comb begin
        unused_branch_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_branch_s = unused_branch_s ^ rob_outputs[i].is_branch;
        end
    end

    // Walk slots oldest first; the first blocking slot ends the scan, and a
    // retiring mispredict or halt is always the last slot taken.
    always_comb begin
        count      = '0;
        stop_slot  = '0;
        mispredict = 1'b0;
        halt       = 1'b0;
        store      = 1'b0;
        stop_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (stop_s) begin
                stop_s = 1'b1;
            end else if ((NUM_SCALAR_BITS'(i) >= rob_outputs_valid) ||
                         !rob_outputs[i].complete ||
                         (rob_outputs[i].is_store && (!sq_retire_ready || store))) begin
                stop_s = 1'b1;
            end else begin
                count     = NUM_SCALAR_BITS'(i + 1);
                stop_slot = SLOT_BITS'(i);
                if (rob_outputs[i].is_store) begin
                    store = 1'b1;
                end else begin
                    store = store;
                end
                if (rob_outputs[i].halt) begin
                    halt   = 1'b1;
                    stop_s = 1'b1;
                end else if (rob_outputs[i].mispredict) begin
                    mispredict = 1'b1;
                    stop_s     = 1'b1;
                end else begin
                    stop_s = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/retire_ctrl.sv
// Retire-stage controller: retirement count, free-list release, mispredict
// flush with ROB tail restore, recovery freeze and halt.
// Optional statistics counters are built when RETIRE_STATS_EN is defined.
module retire_ctrl
    import retire_ctrl_pkg::*;
#(
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  ROB_PACKET [N-1:0]                  rob_outputs,
    input  logic [NUM_SCALAR_BITS-1:0]         rob_outputs_valid,
    input  logic [ROB_SZ_BITS-1:0]             rob_head,
    input  logic                               sq_retire_ready,
    output logic [NUM_SCALAR_BITS-1:0]         num_retiring,
    output logic [N-1:0]                       free_valid,
    output logic [N-1:0][PHYS_REG_BITS-1:0]    free_regs,
    output logic                               store_commit,
    output logic                               flush,
    output logic                               tail_restore_valid,
    output logic [ROB_SZ_BITS-1:0]             tail_restore,
    output logic                               halted
`ifdef RETIRE_STATS_EN
    ,
    output logic [63:0]                        retired_count,
    output logic [31:0]                        flush_count
`endif
);

    localparam int RCNT_W = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

    RETIRE_STATE                state_q, state_d;
    logic [RCNT_W-1:0]          recover_cnt_q, recover_cnt_d;

    logic [NUM_SCALAR_BITS-1:0] scan_count_s;
    logic [SLOT_BITS-1:0]       scan_slot_s;
    logic                       scan_misp_s;
    logic                       scan_halt_s;
    logic                       scan_store_s;
    logic [ROB_SZ_BITS:0]       tail_sum_s;

    retire_scan u_scan (
        .rob_outputs       (rob_outputs),
        .rob_outputs_valid (rob_outputs_valid),
        .sq_retire_ready   (sq_retire_ready),
        .count             (scan_count_s),
        .stop_slot         (scan_slot_s),
        .mispredict        (scan_misp_s),
        .halt              (scan_halt_s),
        .store             (scan_store_s)
    );

    // New tail is one past the mispredicted slot, wrapped at ROB_SZ.
    always_comb begin
        tail_sum_s = {1'b0, rob_head} + (ROB_SZ_BITS + 1)'(scan_slot_s) + (ROB_SZ_BITS + 1)'(1);
        if (tail_sum_s >= (ROB_SZ_BITS + 1)'(ROB_SZ)) begin
            tail_sum_s = tail_sum_s - (ROB_SZ_BITS + 1)'(ROB_SZ);
        end else begin
            tail_sum_s = tail_sum_s;
        end
    end

    // FSM next state and output muxing; everything is forced quiet while
    // reset is held so the ROB and free list see no strobes.
    always_comb begin
        state_d            = state_q;
        recover_cnt_d      = recover_cnt_q;
        num_retiring       = '0;
        free_valid         = '0;
        free_regs          = '0;
        store_commit       = 1'b0;
        flush              = 1'b0;
        tail_restore_valid = 1'b0;
        tail_restore       = '0;
        halted             = 1'b0;
        if (!reset) begin
            state_d       = RUN;
            recover_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    num_retiring = scan_count_s;
                    store_commit = scan_store_s;
                    for (int i = 0; i < N; i++) begin
                        if (NUM_SCALAR_BITS'(i) < scan_count_s) begin
                            free_valid[i] = rob_outputs[i].has_dest &&
                                            (rob_outputs[i].told_reg != PHYS_REG_BITS'(0));
                            free_regs[i]  = rob_outputs[i].told_reg;
                        end else begin
                            free_valid[i] = 1'b0;
                            free_regs[i]  = '0;
                        end
                    end
                    if (scan_halt_s) begin
                        state_d = HALTED;
                    end else if (scan_misp_s) begin
                        flush              = 1'b1;
                        tail_restore_valid = 1'b1;
                        tail_restore       = tail_sum_s[ROB_SZ_BITS-1:0];
                        if (RECOVER_CYCLES == 0) begin
                            state_d = RUN;
                        end else begin
                            state_d       = RECOVER;
                            recover_cnt_d = RCNT_W'(RECOVER_CYCLES);
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                RECOVER: begin
                    if (recover_cnt_q <= RCNT_W'(1)) begin
                        state_d       = RUN;
                        recover_cnt_d = '0;
                    end else begin
                        recover_cnt_d = recover_cnt_q - RCNT_W'(1);
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d       = RUN;
                    recover_cnt_d = '0;
                end
            endcase
        end
    end

    // State and recovery counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            recover_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            recover_cnt_q <= recover_cnt_d;
        end
    end

`ifdef RETIRE_STATS_EN
    logic [63:0] retired_count_q, retired_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Running totals of retired instructions and flushes.
    always_comb begin
        retired_count_d = retired_count_q + 64'(num_retiring);
        if (flush) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count_q <= 64'd0;
            flush_count_q   <= 32'd0;
        end else begin
            retired_count_q <= retired_count_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign retired_count = retired_count_q;
    assign flush_count   = flush_count_q;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed bench for retire_ctrl (N=3, ROB_SZ=32, PHYS_REG_BITS=6,
// RECOVER_CYCLES=2). Inputs change shortly after the rising edge and the
// combinational outputs are sampled 1 time unit later.
module tb_retire_ctrl;
    import retire_ctrl_pkg::*;

    logic                            clock;
    logic                            reset;
    ROB_PACKET [N-1:0]               rob_outputs;
    logic [NUM_SCALAR_BITS-1:0]      rob_outputs_valid;
    logic [ROB_SZ_BITS-1:0]          rob_head;
    logic                            sq_retire_ready;
    logic [NUM_SCALAR_BITS-1:0]      num_retiring;
    logic [N-1:0]                    free_valid;
    logic [N-1:0][PHYS_REG_BITS-1:0] free_regs;
    logic                            store_commit;
    logic                            flush;
    logic                            tail_restore_valid;
    logic [ROB_SZ_BITS-1:0]          tail_restore;
    logic                            halted;
`ifdef RETIRE_STATS_EN
    logic [63:0]                     retired_count;
    logic [31:0]                     flush_count;
`endif

    int checks;
    int errors;

    retire_ctrl #(.RECOVER_CYCLES(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .rob_outputs        (rob_outputs),
        .rob_outputs_valid  (rob_outputs_valid),
        .rob_head           (rob_head),
        .sq_retire_ready    (sq_retire_ready),
        .num_retiring       (num_retiring),
        .free_valid         (free_valid),
        .free_regs          (free_regs),
        .store_commit       (store_commit),
        .flush              (flush),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore       (tail_restore),
        .halted             (halted)
`ifdef RETIRE_STATS_EN
        ,
        .retired_count      (retired_count),
        .flush_count        (flush_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic ROB_PACKET mk(input logic c, input logic st, input logic br,
                                     input logic mp, input logic h, input logic hd,
                                     input logic [PHYS_REG_BITS-1:0] t);
        ROB_PACKET p;
        p.complete   = c;
        p.is_store   = st;
        p.is_branch  = br;
        p.mispredict = mp;
        p.halt       = h;
        p.has_dest   = hd;
        p.told_reg   = t;
        return p;
    endfunction

    task automatic plain_slots();
        rob_outputs[0]    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd7);
        rob_outputs[1]    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8);
        rob_outputs[2]    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd9);
        rob_outputs_valid = 2'd3;
        sq_retire_ready   = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rob_head = 5'd5;
        plain_slots();
        #2;
        checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL reset_num got %0d want 0", num_retiring); end
        checks++; if (free_valid !== 3'b000) begin errors++; $display("FAIL reset_free_valid got %b want 000", free_valid); end
        checks++; if ({flush, tail_restore_valid, store_commit, halted} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b want 0000", {flush, tail_restore_valid, store_commit, halted}); end
        checks++; if (tail_restore !== 5'd0) begin errors++; $display("FAIL reset_tail got %0d want 0", tail_restore); end
        next_cycle();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_full_retire();
        rob_head = 5'd5;
        plain_slots();
        #1;
        checks++; if (num_retiring !== 2'd3) begin errors++; $display("FAIL full_num got %0d want 3", num_retiring); end
        checks++; if (free_valid !== 3'b111) begin errors++; $display("FAIL full_free_valid got %b want 111", free_valid); end
        checks++; if (free_regs !== {6'd9, 6'd8, 6'd7}) begin errors++; $display("FAIL full_free_regs got %h want %h", free_regs, {6'd9, 6'd8, 6'd7}); end
        checks++; if ({flush, store_commit} !== 2'b00) begin errors++; $display("FAIL full_strobes got %b want 00", {flush, store_commit}); end
        next_cycle();
        rob_outputs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
        rob_outputs[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9);
        #1;
        checks++; if (free_valid !== 3'b001) begin errors++; $display("FAIL dest_free_valid got %b want 001", free_valid); end
        checks++; if (free_regs !== {6'd9, 6'd0, 6'd7}) begin errors++; $display("FAIL dest_free_regs got %h want %h", free_regs, {6'd9, 6'd0, 6'd7}); end
        next_cycle();
        plain_slots();
        rob_outputs_valid = 2'd2;
        #1;
        checks++; if (num_retiring !== 2'd2) begin errors++; $display("FAIL valid2_num got %0d want 2", num_retiring); end
        checks++; if (free_regs !== {6'd0, 6'd8, 6'd7}) begin errors++; $display("FAIL valid2_free_regs got %h want %h", free_regs, {6'd0, 6'd8, 6'd7}); end
        next_cycle();
        rob_outputs_valid = 2'd0;
        #1;
        checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL valid0_num got %0d want 0", num_retiring); end
        next_cycle();
        rob_outputs_valid = 2'd3;
        #1;
        checks++; if (num_retiring !== 2'd3) begin errors++; $display("FAIL after_valid0_num got %0d want 3", num_retiring); end
        next_cycle();
    endtask

    task automatic test_incomplete();
        plain_slots();
        rob_outputs[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8);
        #1;
        checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL incomplete_num got %0d want 1", num_retiring); end
        checks++; if (free_valid !== 3'b001) begin errors++; $display("FAIL incomplete_free_valid got %b want 001", free_valid); end
        next_cycle();
    endtask

    task automatic test_stores();
        plain_slots();
        rob_outputs[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        rob_outputs[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        #1;
        checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL store_ready_num got %0d want 1", num_retiring); end
        checks++; if (store_commit !== 1'b1) begin errors++; $display("FAIL store_ready_commit got %b want 1", store_commit); end
        next_cycle();
        sq_retire_ready = 1'b0;
        #1;
        checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL store_busy_num got %0d want 0", num_retiring); end
        checks++; if (store_commit !== 1'b0) begin errors++; $display("FAIL store_busy_commit got %b want 0", store_commit); end
        next_cycle();
    endtask

    task automatic test_mispredict();
        plain_slots();
        rob_head       = 5'd31;
        rob_outputs[1] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd11);
        #1;
        checks++; if (num_retiring !== 2'd2) begin errors++; $display("FAIL misp_num got %0d want 2", num_retiring); end
        checks++; if ({flush, tail_restore_valid} !== 2'b11) begin errors++; $display("FAIL misp_flush got %b want 11", {flush, tail_restore_valid}); end
        checks++; if (tail_restore !== 5'd1) begin errors++; $display("FAIL misp_tail got %0d want 1", tail_restore); end
        checks++; if (free_valid !== 3'b011) begin errors++; $display("FAIL misp_free_valid got %b want 011", free_valid); end
        next_cycle();
        plain_slots();
        #1;
        checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL recover1_num got %0d want 0", num_retiring); end
        checks++; if ({flush, free_valid} !== 4'b0000) begin errors++; $display("FAIL recover1_strobes got %b want 0000", {flush, free_valid}); end
        next_cycle();
        checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL recover2_num got %0d want 0", num_retiring); end
        next_cycle();
        checks++; if (num_retiring !== 2'd3) begin errors++; $display("FAIL resume_num got %0d want 3", num_retiring); end
        next_cycle();
    endtask

    task automatic test_halt();
        plain_slots();
        rob_head       = 5'd5;
        rob_outputs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7);
        #1;
        checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL halt_num got %0d want 1", num_retiring); end
        checks++; if ({halted, flush} !== 2'b00) begin errors++; $display("FAIL halt_same_cycle got %b want 00", {halted, flush}); end
        next_cycle();
        plain_slots();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({halted, num_retiring} !== 3'b100) begin errors++; $display("FAIL halted_cycle%0d got %b want 100", c, {halted, num_retiring}); end
            next_cycle();
        end
        reset = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b want 0", halted); end
        reset = 1'b1;
        #1;
        checks++; if (num_retiring !== 2'd3) begin errors++; $display("FAIL halt_release_num got %0d want 3", num_retiring); end
        next_cycle();
    endtask

    task automatic test_halt_mispredict();
        plain_slots();
        rob_outputs[0] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5);
        #1;
        checks++; if (num_retiring !== 2'd1) begin errors++; $display("FAIL halt_misp_num got %0d want 1", num_retiring); end
        checks++; if ({flush, tail_restore_valid} !== 2'b00) begin errors++; $display("FAIL halt_misp_flush got %b want 00", {flush, tail_restore_valid}); end
        next_cycle();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_misp_halted got %b want 1", halted); end
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset_in_recover();
        plain_slots();
        rob_head       = 5'd5;
        rob_outputs[2] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd9);
        #1;
        checks++; if ({num_retiring, flush} !== 3'b111) begin errors++; $display("FAIL misp2_num_flush got %b want 111", {num_retiring, flush}); end
        checks++; if (tail_restore !== 5'd8) begin errors++; $display("FAIL misp2_tail got %0d want 8", tail_restore); end
        next_cycle();
        plain_slots();
        #1;
        checks++; if (num_retiring !== 2'd0) begin errors++; $display("FAIL rr_frozen_num got %0d want 0", num_retiring); end
        reset = 1'b0;
        #1;
        checks++; if ({num_retiring, free_valid, tail_restore_valid} !== 6'b000000) begin errors++; $display("FAIL rr_reset_outputs got %b want 000000", {num_retiring, free_valid, tail_restore_valid}); end
        reset = 1'b1;
        #1;
        checks++; if (num_retiring !== 2'd3) begin errors++; $display("FAIL rr_release_num got %0d want 3", num_retiring); end
        next_cycle();
        checks++; if (num_retiring !== 2'd3) begin errors++; $display("FAIL rr_next_num got %0d want 3", num_retiring); end
        next_cycle();
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b0;
        rob_outputs       = '0;
        rob_outputs_valid = 2'd0;
        rob_head          = 5'd0;
        sq_retire_ready   = 1'b0;
        test_reset();
        test_full_retire();
        test_incomplete();
        test_stores();
        test_mispredict();
        test_halt();
        test_halt_mispredict();
        test_reset_in_recover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
